// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, clog2 and parameter-legality check for the FIFO slice
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic bit params_ok(input int width, input int depth, input int af, input int ae);
        return width >= 1 && depth >= 2 && (depth & (depth - 1)) == 0 &&
               af >= 1 && af <= depth && ae >= 0 && ae <= depth - 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port RAM, one write port and one registered read port, no reset
//   clk          clock
//   we/waddr/wdata  write port
//   re/raddr     read port; rdata updates only on re and holds otherwise
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, thresholds, valid strobe and sticky error flags
//   clk, rst            clock, synchronous active-high reset
//   we, data_in         write request and data
//   re                  read request
//   data_out, data_valid  registered read data and one-cycle new-word strobe
//   empty, full, almost_empty, almost_full, count  decodes of the registered occupancy
//   overflow, underflow sticky rejected-write / rejected-read flags
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] data_in,
    input  logic             re,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("sync_fifo_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] rdata;
    logic             rd_ok, wr_ok, loaded;

    // Requests made while rst is high are dropped so they touch neither RAM nor flags.
    assign rd_ok = re & ~empty & ~rst;
    assign wr_ok = we & (~full | rd_ok) & ~rst;

    assign empty        = count == '0;
    assign full         = count == (AW+1)'(DEPTH);
    assign almost_empty = count <= (AW+1)'(AE_LEVEL);
    assign almost_full  = count >= (AW+1)'(AF_LEVEL);

    // The RAM read register has no reset; loaded masks it to zero until the first read after reset.
    assign data_out = loaded ? rdata : '0;

    fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk  (clk),
        .we   (wr_ok),
        .waddr(wr_ptr),
        .wdata(data_in),
        .re   (rd_ok),
        .raddr(rd_ptr),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_valid <= 1'b0;
            loaded     <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            wr_ptr     <= wr_ok ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= rd_ok ? rd_ptr + AW'(1) : rd_ptr;
            count      <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
            data_valid <= rd_ok;
            loaded     <= loaded | rd_ok;
            overflow   <= overflow | (we & ~wr_ok);
            underflow  <= underflow | (re & ~rd_ok);
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed table-driven and sequence checks of sync_fifo_param at default parameters
module tb_sync_fifo_param;

    logic       clk = 1'b0, rst = 1'b1, we = 1'b0, re = 1'b0;
    logic [7:0] data_in = '0, data_out;
    logic       data_valid, empty, full, almost_empty, almost_full, overflow, underflow;
    logic [4:0] count;
    int         n_vec = 0, n_bad = 0;

    sync_fifo_param dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .data_in     (data_in),
        .re          (re),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic       re;
        logic [7:0] din;
        int         cnt;
        logic [7:0] dout;
        logic       dv;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t       tbl[34];
    logic [7:0] q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt, input logic [7:0] dout,
                           input logic dv, input logic ovf, input logic udf);
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".data_out"}, 32'(data_out), 32'(dout));
        chk({tag, ".data_valid"}, 32'(data_valid), 32'(dv));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(udf));
        chk({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
        chk({tag, ".full"}, 32'(full), 32'(cnt == 16));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(cnt >= 14));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(cnt <= 2));
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        we = w;
        re = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 1'b0, 8'(i), i + 1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 8'hAA, 16, 8'h00, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 16; i++)
            tbl[17 + i] = '{1'b0, 1'b1, 8'h00, 15 - i, 8'(i), 1'b1, 1'b1, 1'b0};
        tbl[33] = '{1'b0, 1'b1, 8'h00, 0, 8'h0F, 1'b0, 1'b1, 1'b1};

        step(1'b0, 1'b0, 8'h00);
        do_reset();
        chk_all("reset", 0, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 34; i++) begin
            step(tbl[i].we, tbl[i].re, tbl[i].din);
            chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].dout, tbl[i].dv, tbl[i].ovf, tbl[i].udf);
        end

        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
        chk_all("refill", 16, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h55);
        chk_all("sim_full", 16, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk_all($sformatf("sim_full_rd%0d", i), 15 - i, i < 15 ? 8'(i + 1) : 8'h55, 1'b1, 1'b0, 1'b0);
        end

        do_reset();
        step(1'b1, 1'b1, 8'h33);
        chk_all("sim_empty", 1, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h00);
        chk_all("sim_empty_rd", 0, 8'h33, 1'b1, 1'b0, 1'b1);

        do_reset();
        q.delete();
        for (int i = 0; i < 3; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            step(1'b1, 1'b0, d);
            q.push_back(d);
        end
        begin
            logic [7:0] exp_dout;
            exp_dout = 8'h00;
            for (int c = 0; c < 40; c++) begin
                logic       w, r;
                logic [7:0] d;
                w = q.size() < 15 && (c % 4) != 3;
                r = q.size() > 3 && (c % 3) != 0;
                d = 8'($urandom);
                if (r) exp_dout = q.pop_front();
                if (w) q.push_back(d);
                step(w, r, d);
                chk_all($sformatf("wrap%0d", c), q.size(), exp_dout, r, 1'b0, 1'b0);
            end
        end

        do_reset();
        step(1'b0, 1'b1, 8'h00);
        chk_all("udf_pre", 0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
        chk_all("pre_rst", 9, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h00);
        chk_all("pre_rst_rd", 8, 8'h10, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h19);
        rst = 1'b1;
        step(1'b1, 1'b1, 8'hEE);
        rst = 1'b0;
        chk_all("mid_rst", 0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h77);
        chk_all("post_w", 1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00);
        chk_all("post_r", 0, 8'h77, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00);
        chk_all("post_idle", 0, 8'h77, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
